// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for the single-port Nx32
// BRAM "Memory" block. Requests are sampled in IDLE and serialised. Each
// access drives the active-low read or write enable for exactly one cycle.
// Read data is captured from the memory's registered output and returned
// with a one-cycle acknowledge to the requester that was granted.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> a tie goes to the requester that was not granted last
//   undefined -> fixed priority, requester 0 wins every tie
//
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   rN_req_i/we_i/addr_i/wdata_i request from requester N (0 = CPU, 1 = debug)
//   rN_rdata_o, rN_ack_o         read data and completion pulse to requester N
//   mem_addr_o, mem_data_o       address and write data to Memory
//   mem_wr_no, mem_rd_no         active-low write/read enables to Memory
//   mem_data_i                   registered read data from Memory
//   grant_o                      one-hot owner of the current transaction
//   busy_o                       high whenever the FSM is not in IDLE
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | sample requests and latch the winner's command
// ISSUE   | one enable low at the latched address
// CAPTURE | reads only: memory output valid, copy into the rdata register
// ACK     | ack pulse to the owner; grant is cleared on exit

module mem_arbiter #(
    parameter int WORDS      = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  r0_req_i,
    input  logic                  r0_we_i,
    input  logic [WORDS-1:0]      r0_addr_i,
    input  logic [DATA_WIDTH-1:0] r0_wdata_i,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,
    output logic                  r0_ack_o,
    input  logic                  r1_req_i,
    input  logic                  r1_we_i,
    input  logic [WORDS-1:0]      r1_addr_i,
    input  logic [DATA_WIDTH-1:0] r1_wdata_i,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,
    output logic                  r1_ack_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_no,
    output logic                  mem_rd_no,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [1:0]            grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  we_q, we_d;
    logic [WORDS-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_n_q, wr_n_d;
    logic                  rd_n_q, rd_n_d;
    logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
    logic                  r0_ack_q, r0_ack_d;
    logic                  r1_ack_q, r1_ack_d;
    logic                  busy_q, busy_d;
    logic                  pick_r1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the previous grant; reset as if requester 1 won,
    // so the first tie after reset goes to requester 0.
    logic last_r1_q, last_r1_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r1_q <= 1'b1;
        end else begin
            last_r1_q <= last_r1_d;
        end
    end

    always_comb begin
        last_r1_d = last_r1_q;
        if (state_q == IDLE && (r0_req_i || r1_req_i)) begin
            last_r1_d = pick_r1;
        end
    end

    assign pick_r1 = r1_req_i && (!r0_req_i || !last_r1_q);
`else
    assign pick_r1 = r1_req_i && !r0_req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            r0_ack_q   <= r0_ack_d;
            r1_ack_q   <= r1_ack_d;
            busy_q     <= busy_d;
        end
    end

    // Every output is a register, so the enables and acks are decided one
    // state early: the enable in IDLE, the ack in ISSUE (write) or CAPTURE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    state_d = ISSUE;
                    grant_d = pick_r1 ? 2'b10 : 2'b01;
                    we_d    = pick_r1 ? r1_we_i : r0_we_i;
                    addr_d  = pick_r1 ? r1_addr_i : r0_addr_i;
                    if (we_d) begin
                        wdata_d = pick_r1 ? r1_wdata_i : r0_wdata_i;
                        wr_n_d  = 1'b0;
                    end else begin
                        rd_n_d  = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d  = ACK;
                    r0_ack_d = grant_q[0];
                    r1_ack_d = grant_q[1];
                end else begin
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d  = ACK;
                r0_ack_d = grant_q[0];
                r1_ack_d = grant_q[1];
                if (grant_q[1]) begin
                    r1_rdata_d = mem_data_i;
                end else begin
                    r0_rdata_d = mem_data_i;
                end
            end
            ACK: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign r0_rdata_o = r0_rdata_q;
    assign r1_rdata_o = r1_rdata_q;
    assign r0_ack_o   = r0_ack_q;
    assign r1_ack_o   = r1_ack_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = wdata_q;
    assign mem_wr_no  = wr_n_q;
    assign mem_rd_no  = rd_n_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A behavioural BRAM sits on the memory port.
// Each requester is fed from a queue of transactions (idle gap, we, addr,
// data); the reference model schedules whole transactions by the
// arbitration rule and derives per-cycle expectations from the fixed
// 3-cycle write / 4-cycle read latencies.
module tb_mem_arbiter;

    localparam int W     = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << W;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [W-1:0]  r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
    logic          r0_ack, r1_ack;
    logic [W-1:0]  mem_addr;
    logic [DW-1:0] mem_data_out, mem_data_in;
    logic          mem_wr_n, mem_rd_n;
    logic [1:0]    grant;
    logic          busy;
    logic          mem_init;

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(W), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
        .r0_wdata_i(r0_wdata), .r0_rdata_o(r0_rdata), .r0_ack_o(r0_ack),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
        .r1_wdata_i(r1_wdata), .r1_rdata_o(r1_rdata), .r1_ack_o(r1_ack),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data_out),
        .mem_wr_no(mem_wr_n), .mem_rd_no(mem_rd_n), .mem_data_i(mem_data_in),
        .grant_o(grant), .busy_o(busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h5A5A_0000 + 32'(i);
    endfunction

    // Single-port BRAM with registered read output.
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= init_val(i);
            mem_data_in <= '0;
        end else begin
            if (!mem_wr_n) bram[mem_addr] <= mem_data_out;
            if (!mem_rd_n) mem_data_in <= bram[mem_addr];
        end
    end

    typedef struct {
        int            gap;
        logic          we;
        logic [W-1:0]  addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    logic [1:0] glog[$];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // reference model
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rd0, exp_rd1, m_rval;
    bit            m_active;
    int            m_t0, m_len, m_owner, m_last;
    logic          m_we;
    logic [W-1:0]  m_addr;
    logic [DW-1:0] m_data;

    function automatic txn_t mk(input int gap, input logic we, input int addr,
                                input logic [DW-1:0] data);
        txn_t t;
        t.gap  = gap;
        t.we   = we;
        t.addr = W'(addr);
        t.data = data;
        return t;
    endfunction

    task automatic drive();
        txn_t t;
        r0_req = 1'b0; r0_we = 1'($urandom); r0_addr = W'($urandom); r0_wdata = $urandom;
        r1_req = 1'b0; r1_we = 1'($urandom); r1_addr = W'($urandom); r1_wdata = $urandom;
        if (q0.size() > 0) begin
            t = q0[0];
            if (t.gap > 0) begin
                t.gap--;
                q0[0] = t;
            end else begin
                r0_req = 1'b1; r0_we = t.we; r0_addr = t.addr; r0_wdata = t.data;
            end
        end
        if (q1.size() > 0) begin
            t = q1[0];
            if (t.gap > 0) begin
                t.gap--;
                q1[0] = t;
            end else begin
                r1_req = 1'b1; r1_we = t.we; r1_addr = t.addr; r1_wdata = t.data;
            end
        end
    endtask

    task automatic model_check();
        int         off, w;
        logic       e_busy, e_wr_n, e_rd_n, e_ack0, e_ack1;
        logic [1:0] e_grant;
        if (m_active && cyc >= m_t0 + m_len) m_active = 0;
        if (!m_active && (r0_req || r1_req)) begin
            if (r0_req && r1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w = (m_last == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = r1_req ? 1 : 0;
            end
            m_last   = w;
            m_owner  = w;
            m_active = 1;
            m_t0     = cyc;
            m_we     = w ? r1_we : r0_we;
            m_addr   = w ? r1_addr : r0_addr;
            m_data   = w ? r1_wdata : r0_wdata;
            m_len    = m_we ? 3 : 4;
            if (m_we) ref_mem[m_addr] = m_data;
            else      m_rval = ref_mem[m_addr];
        end
        off     = m_active ? cyc - m_t0 : 0;
        e_busy  = m_active && off >= 1;
        e_grant = e_busy ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00;
        e_wr_n  = !(m_active && off == 1 && m_we);
        e_rd_n  = !(m_active && off == 1 && !m_we);
        e_ack0  = m_active && off == m_len - 1 && m_owner == 0;
        e_ack1  = m_active && off == m_len - 1 && m_owner == 1;
        if (e_ack0 && !m_we) exp_rd0 = m_rval;
        if (e_ack1 && !m_we) exp_rd1 = m_rval;

        tests++; if (busy !== e_busy) begin failed++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
        tests++; if (grant !== e_grant) begin failed++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant); end
        tests++; if (mem_wr_n !== e_wr_n) begin failed++;
            $display("FAIL wr_n cyc=%0d got=%b exp=%b", cyc, mem_wr_n, e_wr_n); end
        tests++; if (mem_rd_n !== e_rd_n) begin failed++;
            $display("FAIL rd_n cyc=%0d got=%b exp=%b", cyc, mem_rd_n, e_rd_n); end
        tests++; if (r0_ack !== e_ack0) begin failed++;
            $display("FAIL ack0 cyc=%0d got=%b exp=%b", cyc, r0_ack, e_ack0); end
        tests++; if (r1_ack !== e_ack1) begin failed++;
            $display("FAIL ack1 cyc=%0d got=%b exp=%b", cyc, r1_ack, e_ack1); end
        tests++; if (r0_rdata !== exp_rd0) begin failed++;
            $display("FAIL rdata0 cyc=%0d got=%h exp=%h", cyc, r0_rdata, exp_rd0); end
        tests++; if (r1_rdata !== exp_rd1) begin failed++;
            $display("FAIL rdata1 cyc=%0d got=%h exp=%h", cyc, r1_rdata, exp_rd1); end
        tests++; if ((mem_wr_n | mem_rd_n) !== 1'b1) begin failed++;
            $display("FAIL enable_excl cyc=%0d got wr_n=%b rd_n=%b exp one high", cyc, mem_wr_n, mem_rd_n); end
        tests++; if ((!mem_wr_n || !mem_rd_n) && busy !== 1'b1) begin failed++;
            $display("FAIL enable_idle cyc=%0d got busy=%b exp 1 while enable low", cyc, busy); end
        if (m_active && off == 1) begin
            glog.push_back(grant);
            tests++; if (mem_addr !== m_addr) begin failed++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, m_addr); end
            if (m_we) begin
                tests++; if (mem_data_out !== m_data) begin failed++;
                    $display("FAIL mem_data cyc=%0d got=%h exp=%h", cyc, mem_data_out, m_data); end
            end
        end
        if (e_ack0) void'(q0.pop_front());
        if (e_ack1) void'(q1.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1 drive();
        @(negedge clk);
        model_check();
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_active) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (q0.size() > 0 || q1.size() > 0 || m_active) begin
            failed++;
            $display("FAIL %s timeout got pending=%0d exp 0", name, q0.size() + q1.size());
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; mem_init = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tests++; if (grant !== 2'b00) begin failed++; $display("FAIL rst_grant got=%b exp=00", grant); end
        tests++; if (mem_wr_n !== 1'b1) begin failed++; $display("FAIL rst_wr_n got=%b exp=1", mem_wr_n); end
        tests++; if (mem_rd_n !== 1'b1) begin failed++; $display("FAIL rst_rd_n got=%b exp=1", mem_rd_n); end
        tests++; if (mem_addr !== '0) begin failed++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        tests++; if (mem_data_out !== '0) begin failed++; $display("FAIL rst_data got=%h exp=0", mem_data_out); end
        tests++; if (r0_rdata !== '0 || r1_rdata !== '0) begin failed++;
            $display("FAIL rst_rdata got=%h/%h exp=0/0", r0_rdata, r1_rdata); end
        tests++; if (r0_ack !== 1'b0 || r1_ack !== 1'b0) begin failed++;
            $display("FAIL rst_ack got=%b%b exp=00", r0_ack, r1_ack); end
        @(posedge clk);
        #1 reset_i = 1'b0; mem_init = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        exp_rd0 = '0; exp_rd1 = '0; m_active = 0; m_last = 1; cyc = 0;
    endtask

    task automatic test_contention();
        logic [1:0] expg [8];
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 1'b0, 1, '0));
            q1.push_back(mk(0, 1'b0, 2, '0));
        end
        run_until_done(200, "contention");
        for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            expg[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            expg[i] = (i < 4) ? 2'b01 : 2'b10;
`endif
        end
        tests++; if (glog.size() !== 8) begin failed++;
            $display("FAIL contention_count got=%0d exp=8", glog.size()); end
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            tests++; if (glog[i] !== expg[i]) begin failed++;
                $display("FAIL contention_order[%0d] got=%b exp=%b", i, glog[i], expg[i]); end
        end
        tests++; if (r0_rdata !== init_val(1)) begin failed++;
            $display("FAIL contention_rd0 got=%h exp=%h", r0_rdata, init_val(1)); end
        tests++; if (r1_rdata !== init_val(2)) begin failed++;
            $display("FAIL contention_rd1 got=%h exp=%h", r1_rdata, init_val(2)); end
    endtask

    task automatic test_write_read();
        q0.push_back(mk(0, 1'b1, 5, 32'hDEAD_BEEF));
        q0.push_back(mk(1, 1'b0, 5, '0));
        run_until_done(100, "write_read");
        tests++; if (r0_rdata !== 32'hDEAD_BEEF) begin failed++;
            $display("FAIL write_read_data got=%h exp=deadbeef", r0_rdata); end
    endtask

    task automatic test_boundary();
        q1.push_back(mk(0, 1'b1, DEPTH - 1, 32'h1234_5678));
        q0.push_back(mk(4, 1'b0, DEPTH - 1, '0));
        run_until_done(100, "boundary_hi");
        tests++; if (r0_rdata !== 32'h1234_5678) begin failed++;
            $display("FAIL boundary_hi got=%h exp=12345678", r0_rdata); end
        q0.push_back(mk(0, 1'b0, 0, '0));
        run_until_done(100, "boundary_lo");
        tests++; if (r0_rdata !== init_val(0)) begin failed++;
            $display("FAIL boundary_addr0 got=%h exp=%h", r0_rdata, init_val(0)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            q0.push_back(mk(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, DEPTH - 1)), $urandom));
            q1.push_back(mk(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, DEPTH - 1)), $urandom));
        end
        run_until_done(5000, "random");
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1 r0_req = 1'b1; r0_we = 1'b0; r0_addr = W'(7); r1_req = 1'b0;
        @(posedge clk);
        #1 r0_req = 1'b0; reset_i = 1'b1;
        @(negedge clk);
        tests++; if (mem_rd_n !== 1'b0) begin failed++;
            $display("FAIL rstmid_issue got rd_n=%b exp=0", mem_rd_n); end
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || grant !== 2'b00) begin failed++;
            $display("FAIL rstmid_idle got busy=%b grant=%b exp 0/00", busy, grant); end
        tests++; if (mem_wr_n !== 1'b1 || mem_rd_n !== 1'b1) begin failed++;
            $display("FAIL rstmid_en got=%b%b exp=11", mem_wr_n, mem_rd_n); end
        tests++; if (r0_rdata !== '0 || r1_rdata !== '0) begin failed++;
            $display("FAIL rstmid_rdata got=%h/%h exp=0/0", r0_rdata, r1_rdata); end
        repeat (4) begin
            tests++; if (r0_ack !== 1'b0 || r1_ack !== 1'b0 || busy !== 1'b0) begin failed++;
                $display("FAIL rstmid_noack got ack=%b%b busy=%b exp 00/0", r0_ack, r1_ack, busy); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write_read();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the Nx32 BRAM `Memory` block. It owns that memory's single address/data port, accepts requests from requester 0 (the CPU data port) and requester 1 (the debug/loader port), and serialises them. It drives the memory's active-low read/write enables one access at a time and returns the memory's registered read data with a per-requester acknowledge.

## Interface
Parameters:
- WORDS, 6: address width in bits; memory depth is 1<<WORDS.
- DATA_WIDTH, 32: data width in bits.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- r0_req_i  in  1  requester 0 request; held high until r0_ack_o.
- r0_we_i  in  1  requester 0: 1 = write, 0 = read.
- r0_addr_i  in  WORDS  requester 0 word address.
- r0_wdata_i  in  DATA_WIDTH  requester 0 write data.
- r0_rdata_o  out  DATA_WIDTH  requester 0 read data; valid while r0_ack_o is high after a read.
- r0_ack_o  out  1  requester 0 one-cycle completion pulse.
- r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_rdata_o, r1_ack_o: same as above, for requester 1.
- mem_addr_o  out  WORDS  to Memory addr_i.
- mem_data_o  out  DATA_WIDTH  to Memory data_i.
- mem_wr_no  out  1  to Memory wr_i; active-low.
- mem_rd_no  out  1  to Memory rd_i; active-low.
- mem_data_i  in  DATA_WIDTH  from Memory data_o.
- grant_o  out  2  one-hot owner of the current transaction; 00 when idle.
- busy_o  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - Sample r0_req_i and r1_req_i.
  - If either is high, pick a winner by the arbitration rule (see Configuration).
  - Latch the winner's we/addr/wdata, set grant_o, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: for exactly one cycle, drive the latched address, then:
  - write: mem_wr_no=0 and mem_data_o=wdata; next state ACK.
  - read: mem_rd_no=0; next state CAPTURE.
- CAPTURE (reads only): mem_data_i is valid this cycle. Latch it into the granted requester's rdata register. Next state ACK.
- ACK: pulse the granted requester's ack_o for one cycle, clear grant_o, then go to IDLE.
- Requests are sampled only in IDLE. A req still high when the FSM returns to IDLE starts a new transaction.
- mem_wr_no and mem_rd_no are never low together, and each is low only in ISSUE.
- All outputs are registered.
- Each rdata_o holds its last read value until that requester's next read completes.
- Requester inputs are ignored outside IDLE. They do not need to be stable after the grant.
- Reset values: state=IDLE, mem_wr_no=1, mem_rd_no=1, mem_addr_o=0, mem_data_o=0, r0/r1_rdata_o=0, r0/r1_ack_o=0, grant_o=00, busy_o=0, round-robin pointer="last grant = requester 1".

## Timing
- Let cycle 0 be the IDLE cycle in which req is sampled high.
- Write: enable low in cycle 1, ack in cycle 2, IDLE in cycle 3. Throughput is one write per 3 cycles.
- Read: enable low in cycle 1, memory data registered at the end of cycle 1, captured in cycle 2, ack plus rdata in cycle 3, IDLE in cycle 4. Throughput is one read per 4 cycles.
- A requester that wants no further access drops req on the clock edge that ends its ack cycle.
- Simultaneous requests in IDLE: exactly one is granted. The loser keeps req high and is served in the next IDLE.
- Reset mid-transaction: the FSM returns to IDLE on the next edge and enables deassert in the same edge. No ack is issued. A write whose ISSUE cycle already completed remains in memory.
- Address width is WORDS, so there is no wrap handling. Every address 0..(1<<WORDS)-1 is legal.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: round-robin. On a tie, grant the requester not granted last; the pointer updates on every grant.
  - Undefined: fixed priority. Requester 0 always wins a tie, and requester 1 can starve under continuous requester 0 traffic.
- Single-requester behaviour and latency are identical in both modes.

## Test plan
- Write then read, requester 0: write 0xDEADBEEF to addr 5, then read addr 5. Required: mem_wr_no low for one cycle with mem_addr_o=5, r0_ack_o in cycle 2; read returns r0_rdata_o=0xDEADBEEF with r0_ack_o in cycle 3.
- Simultaneous reads, with MEM_ARB_ROUND_ROBIN_EN: r0 reads addr 1 and r1 reads addr 2 together, both holding req. Required: grants alternate 0,1,0,1 over 4 transactions and each rdata_o matches its address.
- Same stimulus without the macro: every transaction goes to requester 0 while r0_req_i stays high. Once r0 drops req, r1 is granted in the next IDLE.
- Enable exclusivity: random mixed traffic for 1000 cycles. Assert mem_wr_no and mem_rd_no are never both 0, and each is 0 only while busy_o=1.
- Reset in ISSUE of a read of addr 7: reset_i high for one cycle. Required: the next cycle shows IDLE, enables 1, no ack, and both rdata_o=0.
- Boundary address: write 0x12345678 to addr 63 (WORDS=6) via requester 1, then read it back via requester 0. Required: read returns 0x12345678 and addr 0 is unchanged.
